// File: rtl/rnd_frame_buffer_pkg.sv
// Shared types and helpers for the PRNG-to-core randomness frame buffer.
package rnd_frame_buffer_pkg;

    localparam int unsigned STAT_W = 32;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int unsigned nwords(input int unsigned w_in, input int unsigned w_out);
        return (w_out + w_in - 1) / w_in;
    endfunction

endpackage

// File: rtl/rnd_frame_fifo.sv
// Frame FIFO with wrap-around pointers; dout is forced to zero while empty.
module rnd_frame_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;
    // Memory is never reset, so the head is masked to keep stale data off the bus.
    assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/rnd_frame_buffer.sv
// Gearbox packing PRNG words into core-width frames, plus a prefill-gated frame FIFO.
// Optional saturating usage counters are enabled by defining RND_FRAME_BUFFER_STATS_EN.
module rnd_frame_buffer
    import rnd_frame_buffer_pkg::*;
#(
    parameter int unsigned W_IN    = 512,
    parameter int unsigned W_OUT   = 2720,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned PREFILL = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [W_IN-1:0]            in_rnd,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [W_OUT-1:0]           out_rnd,
    output logic [$clog2(DEPTH+1)-1:0] level
`ifdef RND_FRAME_BUFFER_STATS_EN
    ,
    output logic [STAT_W-1:0]          stat_frames,
    output logic [STAT_W-1:0]          stat_starve
`endif
);

    localparam int unsigned NW   = nwords(W_IN, W_OUT);
    localparam int unsigned WC_W = (NW > 1) ? $clog2(NW) : 1;
    localparam int unsigned LW   = $clog2(DEPTH + 1);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(NW - 1);

    logic [NW*W_IN-1:0] asm_q;
    logic [NW*W_IN-1:0] asm_next;
    logic [WC_W-1:0]    wcnt;
    logic               last_word;
    logic               accept;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    state_t             state;

    assign last_word = (wcnt == WC_LAST);
    assign in_ready  = !flush && !(last_word && full);
    assign accept    = in_valid && in_ready;
    assign push      = accept && last_word;
    assign out_valid = !flush && (state == RUN) && !empty;
    assign pop       = out_valid && out_ready;

    // The completing word is merged combinationally so the frame pushes on the same edge.
    always_comb begin
        asm_next = asm_q;
        for (int unsigned k = 0; k < NW; k++) begin
            if (wcnt == WC_W'(k)) asm_next[k*W_IN +: W_IN] = in_rnd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            asm_q <= '0;
            wcnt  <= '0;
        end else if (flush) begin
            wcnt  <= '0;
        end else if (accept) begin
            asm_q <= asm_next;
            wcnt  <= last_word ? '0 : wcnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state <= FILL;
        end else if (state == FILL && level >= LW'(PREFILL)) begin
            state <= RUN;
        end
    end

    rnd_frame_fifo #(
        .W     (W_OUT),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .push  (push),
        .pop   (pop),
        .din   (asm_next[W_OUT-1:0]),
        .dout  (out_rnd),
        .full  (full),
        .empty (empty),
        .level (level)
    );

`ifdef RND_FRAME_BUFFER_STATS_EN
    // Counters survive flush so they span a whole session between resets.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_frames <= '0;
            stat_starve <= '0;
        end else begin
            if (pop && stat_frames != '1) stat_frames <= stat_frames + 1'b1;
            if (state == RUN && empty && stat_starve != '1) stat_starve <= stat_starve + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_rnd_frame_buffer.sv
// Directed bench for rnd_frame_buffer: main 8->20 bit config plus a 32->32 variant.
module tb_rnd_frame_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, in_valid, out_ready, in_ready, out_valid;
    logic [7:0]  in_rnd;
    logic [19:0] out_rnd;
    logic [2:0]  level;

    logic        v_rst, v_flush, v_in_valid, v_out_ready, v_in_ready, v_out_valid;
    logic [31:0] v_in_rnd, v_out_rnd;
    logic [1:0]  v_level;

`ifdef RND_FRAME_BUFFER_STATS_EN
    logic [31:0] stat_frames, stat_starve, v_stat_frames, v_stat_starve;
`endif

    int n_vec = 0;
    int n_err = 0;

    rnd_frame_buffer #(
        .W_IN(8), .W_OUT(20), .DEPTH(4), .PREFILL(2)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_rnd(in_rnd), .out_valid(out_valid), .out_ready(out_ready), .out_rnd(out_rnd),
        .level(level)
`ifdef RND_FRAME_BUFFER_STATS_EN
        , .stat_frames(stat_frames), .stat_starve(stat_starve)
`endif
    );

    rnd_frame_buffer #(
        .W_IN(32), .W_OUT(32), .DEPTH(2), .PREFILL(1)
    ) dut_v (
        .clk(clk), .rst(v_rst), .flush(v_flush), .in_valid(v_in_valid), .in_ready(v_in_ready),
        .in_rnd(v_in_rnd), .out_valid(v_out_valid), .out_ready(v_out_ready), .out_rnd(v_out_rnd),
        .level(v_level)
`ifdef RND_FRAME_BUFFER_STATS_EN
        , .stat_frames(v_stat_frames), .stat_starve(v_stat_starve)
`endif
    );

    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_rnd = '0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0; #1;
    endtask

    task automatic send_word(input logic [7:0] w);
        in_valid = 1'b1; in_rnd = w;
        @(posedge clk); #1;
        in_valid = 1'b0; #1;
    endtask

    task automatic v_send(input logic [31:0] w);
        v_in_valid = 1'b1; v_in_rnd = w;
        @(posedge clk); #1;
        v_in_valid = 1'b0; #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_vec++; if (out_rnd !== 20'h0) begin n_err++; $display("FAIL reset_out_rnd: got %h want 00000", out_rnd); end
        n_vec++; if (level !== 3'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", level); end
    endtask

    task automatic test_basic();
        do_reset();
        out_ready = 1'b1;
        send_word(8'h11); send_word(8'h22); send_word(8'h33);
        n_vec++; if (level !== 3'd1) begin n_err++; $display("FAIL basic_level1: got %0d want 1", level); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_no_valid: got %b want 0", out_valid); end
        send_word(8'h44); send_word(8'h55); send_word(8'h66);
        n_vec++; if (level !== 3'd2) begin n_err++; $display("FAIL basic_level2: got %0d want 2", level); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_fill_gate: got %b want 0", out_valid); end
        step();
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b want 1", out_valid); end
        n_vec++; if (out_rnd !== 20'h32211) begin n_err++; $display("FAIL basic_frame0: got %h want 32211", out_rnd); end
        step();
        n_vec++; if (out_rnd !== 20'h65544) begin n_err++; $display("FAIL basic_frame1: got %h want 65544", out_rnd); end
        n_vec++; if (level !== 3'd1) begin n_err++; $display("FAIL basic_pop_level: got %0d want 1", level); end
        step();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_drained: got %b want 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_prefill();
        do_reset();
        send_word(8'h01); send_word(8'h02); send_word(8'h03);
        repeat (3) step();
        n_vec++; if (level !== 3'd1) begin n_err++; $display("FAIL prefill_level1: got %0d want 1", level); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL prefill_hold: got %b want 0", out_valid); end
        send_word(8'hA1); send_word(8'hA2); send_word(8'hA3);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL prefill_edge: got %b want 0", out_valid); end
        step();
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL prefill_valid: got %b want 1", out_valid); end
        n_vec++; if (out_rnd !== 20'h30201) begin n_err++; $display("FAIL prefill_head: got %h want 30201", out_rnd); end
    endtask

    task automatic test_full();
        logic [19:0] exp_head [4];
        exp_head[0] = 20'h51413; exp_head[1] = 20'h81716;
        exp_head[2] = 20'hB1A19; exp_head[3] = 20'hE1D1C;
        do_reset();
        for (int i = 0; i < 12; i++) send_word(8'(8'h10 + i));
        n_vec++; if (level !== 3'd4) begin n_err++; $display("FAIL full_level4: got %0d want 4", level); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL full_ready_w13: got %b want 1", in_ready); end
        send_word(8'h1C); send_word(8'h1D);
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_block: got %b want 0", in_ready); end
        in_valid = 1'b1; in_rnd = 8'h1E;
        step();
        n_vec++; if (level !== 3'd4 || in_ready !== 1'b0) begin n_err++; $display("FAIL full_stall: got level %0d ready %b want 4/0", level, in_ready); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0; #1;
        n_vec++; if (in_ready !== 1'b1 || level !== 3'd3) begin n_err++; $display("FAIL full_after_pop: got ready %b level %0d want 1/3", in_ready, level); end
        step();
        in_valid = 1'b0; #1;
        n_vec++; if (level !== 3'd4) begin n_err++; $display("FAIL full_frame5: got %0d want 4", level); end
        out_ready = 1'b1; #1;
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (out_valid !== 1'b1 || out_rnd !== exp_head[i]) begin n_err++; $display("FAIL full_drain%0d: got %b/%h want 1/%h", i, out_valid, out_rnd, exp_head[i]); end
            step();
        end
        n_vec++; if (level !== 3'd0) begin n_err++; $display("FAIL full_empty: got %0d want 0", level); end
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 1; i <= 8; i++) send_word(8'(i));
        n_vec++; if (level !== 3'd2 || out_valid !== 1'b1) begin n_err++; $display("FAIL flush_pre: got level %0d valid %b want 2/1", level, out_valid); end
        flush = 1'b1; in_valid = 1'b1; in_rnd = 8'hEE; out_ready = 1'b1; #1;
        n_vec++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin n_err++; $display("FAIL flush_gate: got ready %b valid %b want 0/0", in_ready, out_valid); end
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; #1;
        n_vec++; if (level !== 3'd0 || out_valid !== 1'b0) begin n_err++; $display("FAIL flush_clear: got level %0d valid %b want 0/0", level, out_valid); end
        send_word(8'h71); send_word(8'h72); send_word(8'h73);
        n_vec++; if (level !== 3'd1 || out_valid !== 1'b0) begin n_err++; $display("FAIL flush_refill1: got level %0d valid %b want 1/0", level, out_valid); end
        send_word(8'h81); send_word(8'h82); send_word(8'h83);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_refill2: got %b want 0", out_valid); end
        step();
        n_vec++; if (out_valid !== 1'b1 || out_rnd !== 20'h37271) begin n_err++; $display("FAIL flush_fresh: got %b/%h want 1/37271", out_valid, out_rnd); end
    endtask

    task automatic test_rst_midstream();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_rnd = 8'(8'h40 + i); out_ready = (i % 2) == 1;
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_vec++; if (out_rnd !== 20'h0) begin n_err++; $display("FAIL rst_out_rnd: got %h want 00000", out_rnd); end
        n_vec++; if (level !== 3'd0) begin n_err++; $display("FAIL rst_level: got %0d want 0", level); end
        for (int i = 1; i <= 6; i++) send_word(8'(8'h90 + i));
        step();
        n_vec++; if (out_valid !== 1'b1 || out_rnd !== 20'h39291) begin n_err++; $display("FAIL rst_fresh: got %b/%h want 1/39291", out_valid, out_rnd); end
    endtask

    task automatic test_variant();
        v_rst = 1'b1;
        step();
        v_rst = 1'b0; v_out_ready = 1'b1; #1;
        n_vec++; if (v_in_ready !== 1'b1 || v_out_valid !== 1'b0 || v_level !== 2'd0) begin n_err++; $display("FAIL var_reset: got %b/%b/%0d want 1/0/0", v_in_ready, v_out_valid, v_level); end
        v_send(32'hDEADBEEF);
        n_vec++; if (v_level !== 2'd1 || v_out_valid !== 1'b0) begin n_err++; $display("FAIL var_fill: got level %0d valid %b want 1/0", v_level, v_out_valid); end
        step();
        n_vec++; if (v_out_valid !== 1'b1 || v_out_rnd !== 32'hDEADBEEF) begin n_err++; $display("FAIL var_first: got %b/%h want 1/deadbeef", v_out_valid, v_out_rnd); end
        step();
        n_vec++; if (v_out_valid !== 1'b0 || v_level !== 2'd0) begin n_err++; $display("FAIL var_pop: got valid %b level %0d want 0/0", v_out_valid, v_level); end
        v_send(32'hCAFEF00D);
        n_vec++; if (v_out_valid !== 1'b1 || v_out_rnd !== 32'hCAFEF00D) begin n_err++; $display("FAIL var_run_latency: got %b/%h want 1/cafef00d", v_out_valid, v_out_rnd); end
        step();
        n_vec++; if (v_out_valid !== 1'b0) begin n_err++; $display("FAIL var_pop2: got %b want 0", v_out_valid); end
`ifdef RND_FRAME_BUFFER_STATS_EN
        n_vec++; if (v_stat_frames !== 32'd2) begin n_err++; $display("FAIL var_stat_frames: got %0d want 2", v_stat_frames); end
        n_vec++; if (v_stat_starve !== 32'd1) begin n_err++; $display("FAIL var_stat_starve1: got %0d want 1", v_stat_starve); end
`endif
        repeat (5) step();
`ifdef RND_FRAME_BUFFER_STATS_EN
        n_vec++; if (v_stat_starve !== 32'd6) begin n_err++; $display("FAIL var_stat_starve6: got %0d want 6", v_stat_starve); end
        n_vec++; if (v_stat_frames !== 32'd2) begin n_err++; $display("FAIL var_stat_frames_idle: got %0d want 2", v_stat_frames); end
`endif
        n_vec++; if (v_level !== 2'd0 || v_in_ready !== 1'b1) begin n_err++; $display("FAIL var_idle: got level %0d ready %b want 0/1", v_level, v_in_ready); end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_rnd = '0;
        v_rst = 1'b1; v_flush = 1'b0; v_in_valid = 1'b0; v_out_ready = 1'b0; v_in_rnd = '0;
        test_reset();
        test_basic();
        test_prefill();
        test_full();
        test_flush();
        test_rst_midstream();
        test_variant();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
